ammo_reloader: RTL and testbench
================================

// Module: ammo_reloader
// PURPOSE
//  Supply side of the weapon ammo counter: holds a reserve magazine and transfers ammo
//  into the weapon counter in chunks. Each chunk produces a one-cycle load pulse that
//  carries the new absolute ammo value.
//  Sits beside the weapons block. ammo_out/load drive the weapon counter's in/load inputs.
//  Enforces the rule that no transfer happens while the weapon is firing.
// PARAMETERS
//  N             9    width of all ammo quantities
//  CHUNK         16   max rounds moved per TRANSFER cycle
//  RELOAD_DELAY  4    cycles spent in PREP before first chunk (>=1)
//  LOW_THRESH    32   auto-reload trigger level (used only with AUTO_RELOAD_EN)
// PORTS
//  clk          in   1  rising-edge clock
//  rst          in   1  synchronous, active-high reset
//  store_load   in   1  add store_in to reserve this cycle
//  store_in     in   N  resupply quantity
//  reload_req   in   1  weapon/operator requests reload (level)
//  firing       in   1  weapon currently shooting
//  weapon_ammo  in   N  current weapon counter value
//  weapon_max   in   N  weapon counter capacity
//  ammo_out     out  N  new absolute ammo value, valid when load=1
//  load         out  1  one-cycle strobe per chunk
//  busy         out  1  high in PREP or TRANSFER
//  done         out  1  one-cycle pulse on normal completion
//  error        out  1  one-cycle pulse on rejected or aborted reload
//  reserve      out  N  rounds remaining in magazine
// BEHAVIOUR
//  Reset: state IDLE, reserve=0, shadow=0, ammo_out=0. load, busy, done and error all 0.
//  FSM IDLE -> PREP -> TRANSFER -> DONE -> IDLE. All outputs are registered.
//  IDLE, when a request (reload_req) is seen:
//   - If reserve==0 or firing=1: error pulse next cycle, stay in IDLE.
//   - Else if weapon_ammo>=weapon_max: no-op, stay in IDLE, no error.
//   - Else: shadow<=weapon_ammo, delay counter<=RELOAD_DELAY-1, go to PREP.
//  PREP: count down to 0, then go to TRANSFER. Nothing moves in PREP.
//  TRANSFER, each cycle:
//   - k = min(CHUNK, reserve, weapon_max-shadow).
//   - shadow+=k, reserve-=k.
//   - ammo_out<=shadow+k, load=1 next cycle.
//   - When shadow+k==weapon_max or reserve-k==0, go to DONE.
//  DONE: done=1 for one cycle, then IDLE. A held reload_req re-arms only after one IDLE cycle.
//  firing=1 in PREP or TRANSFER: abort to IDLE with an error pulse, no load that cycle.
//   Rounds already loaded stay loaded and are not refunded.
//  store_load: reserve = sat(reserve - k + store_in), saturating at 2^N-1.
//   The deduction is applied first and no underflow is possible.
//  weapon_max changing mid-reload: k uses the current value. If shadow>=weapon_max, k=0 -> DONE.
//  rst at any cycle overrides everything. No partial load is emitted on that edge.
//  All arithmetic is unsigned N-bit, with comparisons done at N+1 bits to avoid wrap.
// CONFIGURATION
//  AUTO_RELOAD_EN defined:
//   - IDLE also starts a reload when weapon_ammo<LOW_THRESH, firing=0 and reserve>0.
//   - The auto trigger never raises error: an empty reserve is silently ignored.
//  AUTO_RELOAD_EN undefined: only reload_req starts a reload. LOW_THRESH is unused.
// STRUCTURE
//  Package ammo_pkg: state enum (IDLE, PREP, TRANSFER, DONE) and the N default.
//   Also a sat_add / min3 function pair shared with the weapon counter.
//  Sub-module chunk_calc: combinational k = min3(CHUNK, reserve, weapon_max-shadow).
//  Top holds the FSM, delay counter, shadow and reserve registers.
// TESTING
//  1. rst; store 100; weapon_ammo=0, max=40; reload_req.
//     -> after 4 PREP cycles, loads 16,32,40; done; reserve=60.
//  2. reserve=0, reload_req -> error pulse only, no load, state stays IDLE.
//  3. reserve=100, weapon 0/200, firing asserted in 2nd TRANSFER cycle
//     -> one load (16), error pulse, reserve=84.
//  4. reserve=510, store_load 20 during a 16-round chunk -> reserve=511 (saturated).
//  5. weapon_ammo==weapon_max=50, reload_req -> no load, no error, no done.
//  6. AUTO_RELOAD_EN: weapon_ammo 31, reserve 10, max 100, no req
//     -> single load to 41, done, reserve=0.

Source files
------------

// File: rtl/ammo_pkg.sv
// Shared definitions for the ammo supply path: reloader state encoding, the
// default ammo width, and the saturating-add / three-way-minimum helpers that
// the weapon counter also uses.
package ammo_pkg;

    // Default width of every ammo quantity (rounds), weapon and reserve alike.
    localparam int AMMO_N = 9;

    // Reloader sequencing: wait out the reload delay, then move rounds in chunks.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREP     = 2'd1,
        TRANSFER = 2'd2,
        DONE     = 2'd3
    } reload_state_t;

    // Unsigned add clamped to limit. The sum is formed one bit wider so a
    // carry out can never wrap back under the limit.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] limit);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, limit}) begin
            return limit;
        end
        return sum[31:0];
    endfunction

    // Smallest of three unsigned quantities.
    function automatic logic [31:0] min3(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [31:0] c);
        logic [31:0] m;
        m = a;
        if (b < m) begin
            m = b;
        end
        if (c < m) begin
            m = c;
        end
        return m;
    endfunction

endpackage

// File: rtl/ammo_reloader_chunk_calc.sv
// Chunk size for one TRANSFER cycle: never more than CHUNK rounds, never more
// than the reserve holds, never more than the room left in the weapon. Room is
// worked out one bit wider so a weapon_max that drops below the shadow count
// gives zero room instead of a huge wrapped value.
module chunk_calc
    import ammo_pkg::*;
#(
    parameter int N     = AMMO_N,
    parameter int CHUNK = 16
)(
    input  logic [N-1:0] reserve,
    input  logic [N-1:0] shadow,
    input  logic [N-1:0] weapon_max,
    output logic [N-1:0] k
);

    logic [N:0] room;

    // Room left in the weapon, then the three-way minimum.
    always_comb begin
        room = '0;
        if ({1'b0, weapon_max} > {1'b0, shadow}) begin
            room = {1'b0, weapon_max} - {1'b0, shadow};
        end
        k = N'(min3(32'(CHUNK), 32'(reserve), 32'(room)));
    end

endmodule

// File: rtl/ammo_reloader.sv
// Ammo reloader: keeps a reserve magazine and feeds the weapon counter in
// chunks, each chunk a one-cycle load strobe carrying the new absolute ammo
// value. Firing during a reload aborts it with an error pulse; rounds already
// loaded are kept.
// Optional feature: define AUTO_RELOAD_EN to let the block start a reload on
// its own when the weapon drops below LOW_THRESH (that parameter only exists
// in that build).
module ammo_reloader
    import ammo_pkg::*;
#(
    parameter int N            = AMMO_N,
    parameter int CHUNK        = 16,
    parameter int RELOAD_DELAY = 4
`ifdef AUTO_RELOAD_EN
    ,
    parameter int LOW_THRESH   = 32
`endif
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         store_load,
    input  logic [N-1:0] store_in,
    input  logic         reload_req,
    input  logic         firing,
    input  logic [N-1:0] weapon_ammo,
    input  logic [N-1:0] weapon_max,
    output logic [N-1:0] ammo_out,
    output logic         load,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [N-1:0] reserve
);

    // Delay counter is loaded with RELOAD_DELAY-1, so this many bits suffice.
    localparam int DW = (RELOAD_DELAY > 1) ? $clog2(RELOAD_DELAY) : 1;
    localparam logic [31:0] RESERVE_MAX = 32'((2 ** N) - 1);

    reload_state_t state;
    logic [DW-1:0] delay_cnt;
    logic [N-1:0]  shadow;
    logic          rearm_hold;

    logic [N-1:0]  chunk_k;
    logic [N-1:0]  take;
    logic [N-1:0]  reserve_after;
    logic [N-1:0]  store_add;
    logic [N-1:0]  reserve_next;
    logic [N:0]    shadow_sum;
    logic          weapon_full;
    logic          auto_trig;

    chunk_calc #(
        .N     (N),
        .CHUNK (CHUNK)
    ) u_chunk_calc (
        .reserve    (reserve),
        .shadow     (shadow),
        .weapon_max (weapon_max),
        .k          (chunk_k)
    );

`ifdef AUTO_RELOAD_EN
    // Self-started reload when the weapon runs low. An empty reserve simply
    // keeps it from firing, so it never produces an error.
    assign auto_trig = ({1'b0, weapon_ammo} < (N+1)'(LOW_THRESH)) && !firing && (reserve != '0);
`else
    // Only an explicit request can start a reload in this build.
    assign auto_trig = 1'b0;
`endif

    // Rounds actually leaving the reserve this cycle, the resupply amount, and
    // the resulting reserve. The chunk is taken first, so the subtraction can
    // never underflow; only the resupply needs saturating.
    always_comb begin
        take = '0;
        if ((state == TRANSFER) && !firing) begin
            take = chunk_k;
        end
        store_add = '0;
        if (store_load) begin
            store_add = store_in;
        end
        reserve_after = reserve - take;
        reserve_next  = N'(sat_add(32'(reserve_after), 32'(store_add), RESERVE_MAX));
        shadow_sum    = {1'b0, shadow} + {1'b0, chunk_k};
        weapon_full   = {1'b0, weapon_ammo} >= {1'b0, weapon_max};
    end

    // Reload sequencer plus the reserve, shadow and delay registers; every
    // output is registered here so the weapon counter sees clean strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            delay_cnt  <= '0;
            shadow     <= '0;
            rearm_hold <= 1'b0;
            reserve    <= '0;
            ammo_out   <= '0;
            load       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            load    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            reserve <= reserve_next;

            case (state)
                IDLE: begin
                    if (rearm_hold) begin
                        rearm_hold <= 1'b0;
                    end else if (reload_req) begin
                        if ((reserve == '0) || firing) begin
                            error <= 1'b1;
                        end else if (!weapon_full) begin
                            shadow    <= weapon_ammo;
                            delay_cnt <= DW'(RELOAD_DELAY - 1);
                            busy      <= 1'b1;
                            state     <= PREP;
                        end
                    end else if (auto_trig && !weapon_full) begin
                        shadow    <= weapon_ammo;
                        delay_cnt <= DW'(RELOAD_DELAY - 1);
                        busy      <= 1'b1;
                        state     <= PREP;
                    end
                end

                PREP: begin
                    if (firing) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (delay_cnt == '0) begin
                        state <= TRANSFER;
                    end else begin
                        delay_cnt <= delay_cnt - 1'b1;
                    end
                end

                TRANSFER: begin
                    if (firing) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        shadow <= shadow_sum[N-1:0];
                        if (chunk_k != '0) begin
                            ammo_out <= shadow_sum[N-1:0];
                            load     <= 1'b1;
                        end
                        if ((shadow_sum >= {1'b0, weapon_max}) || (reserve_after == '0)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                DONE: begin
                    rearm_hold <= 1'b1;
                    state      <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ammo_reloader.sv
// Directed testbench for ammo_reloader: reset state, chunked transfer, empty
// reserve rejection, firing abort, reserve saturation, full-weapon no-op,
// reset during transfer, held request re-arm, and (with AUTO_RELOAD_EN) the
// low-ammo auto trigger.
module tb_ammo_reloader;

    localparam int N = 9;

    logic         clk = 1'b0;
    logic         rst;
    logic         store_load;
    logic [N-1:0] store_in;
    logic         reload_req;
    logic         firing;
    logic [N-1:0] weapon_ammo;
    logic [N-1:0] weapon_max;
    logic [N-1:0] ammo_out;
    logic         load;
    logic         busy;
    logic         done;
    logic         error;
    logic [N-1:0] reserve;

    int pass_cnt  = 0;
    int check_cnt = 0;
    int n_loads;
    int n_done;
    int n_err;
    int load_idx[16];
    int load_val[16];

    ammo_reloader #(
        .N            (N),
        .CHUNK        (16),
        .RELOAD_DELAY (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .store_load  (store_load),
        .store_in    (store_in),
        .reload_req  (reload_req),
        .firing      (firing),
        .weapon_ammo (weapon_ammo),
        .weapon_max  (weapon_max),
        .ammo_out    (ammo_out),
        .load        (load),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .reserve     (reserve)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        store_load  = 1'b0;
        store_in    = '0;
        reload_req  = 1'b0;
        firing      = 1'b0;
        weapon_ammo = '0;
        weapon_max  = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic store(input int qty);
        store_load = 1'b1;
        store_in   = N'(qty);
        tick();
        store_load = 1'b0;
        store_in   = '0;
    endtask

    // Run a fixed number of cycles, recording every load strobe (cycle index
    // and value), done pulses and error pulses.
    task automatic capture(input int cycles);
        n_loads = 0;
        n_done  = 0;
        n_err   = 0;
        for (int j = 0; j < 16; j++) begin
            load_idx[j] = -1;
            load_val[j] = -1;
        end
        for (int i = 1; i <= cycles; i++) begin
            tick();
            if (load === 1'b1) begin
                if (n_loads < 16) begin
                    load_idx[n_loads] = i;
                    load_val[n_loads] = int'(ammo_out);
                end
                n_loads++;
            end
            if (done === 1'b1) n_done++;
            if (error === 1'b1) n_err++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_cnt++; if (reserve !== 9'd0) $display("[TB] FAIL reset_reserve: got %0d expected 0", reserve); else pass_cnt++;
        check_cnt++; if (ammo_out !== 9'd0) $display("[TB] FAIL reset_ammo_out: got %0d expected 0", ammo_out); else pass_cnt++;
        check_cnt++; if ({load, busy, done, error} !== 4'b0000) $display("[TB] FAIL reset_flags: got %b expected 0000", {load, busy, done, error}); else pass_cnt++;
    endtask

    task automatic test_basic_transfer();
        do_reset();
        store(100);
        check_cnt++; if (reserve !== 9'd100) $display("[TB] FAIL basic_store: got %0d expected 100", reserve); else pass_cnt++;
        weapon_ammo = 9'd0;
        weapon_max  = 9'd40;
        reload_req  = 1'b1;
        tick();
        reload_req = 1'b0;
        check_cnt++; if (busy !== 1'b1) $display("[TB] FAIL basic_busy: got %b expected 1", busy); else pass_cnt++;
        capture(12);
        check_cnt++; if (n_loads != 3) $display("[TB] FAIL basic_nloads: got %0d expected 3", n_loads); else pass_cnt++;
        check_cnt++; if (load_idx[0] != 5) $display("[TB] FAIL basic_first_load_cycle: got %0d expected 5", load_idx[0]); else pass_cnt++;
        check_cnt++; if (load_val[0] != 16) $display("[TB] FAIL basic_load0: got %0d expected 16", load_val[0]); else pass_cnt++;
        check_cnt++; if (load_val[1] != 32) $display("[TB] FAIL basic_load1: got %0d expected 32", load_val[1]); else pass_cnt++;
        check_cnt++; if (load_val[2] != 40) $display("[TB] FAIL basic_load2: got %0d expected 40", load_val[2]); else pass_cnt++;
        check_cnt++; if (n_done != 1) $display("[TB] FAIL basic_done: got %0d expected 1", n_done); else pass_cnt++;
        check_cnt++; if (n_err != 0) $display("[TB] FAIL basic_err: got %0d expected 0", n_err); else pass_cnt++;
        check_cnt++; if (reserve !== 9'd60) $display("[TB] FAIL basic_reserve: got %0d expected 60", reserve); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("[TB] FAIL basic_idle_busy: got %b expected 0", busy); else pass_cnt++;
    endtask

    task automatic test_empty_reserve();
        do_reset();
        weapon_ammo = 9'd0;
        weapon_max  = 9'd40;
        reload_req  = 1'b1;
        tick();
        reload_req = 1'b0;
        check_cnt++; if (error !== 1'b1) $display("[TB] FAIL empty_error: got %b expected 1", error); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("[TB] FAIL empty_busy: got %b expected 0", busy); else pass_cnt++;
        capture(8);
        check_cnt++; if (n_loads != 0) $display("[TB] FAIL empty_nloads: got %0d expected 0", n_loads); else pass_cnt++;
        check_cnt++; if (n_err != 0) $display("[TB] FAIL empty_extra_err: got %0d expected 0", n_err); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("[TB] FAIL empty_stays_idle: got %b expected 0", busy); else pass_cnt++;
    endtask

    task automatic test_firing_abort();
        do_reset();
        store(100);
        weapon_ammo = 9'd0;
        weapon_max  = 9'd200;
        reload_req  = 1'b1;
        tick();
        reload_req = 1'b0;
        for (int i = 1; i <= 5; i++) tick();
        check_cnt++; if (load !== 1'b1 || ammo_out !== 9'd16) $display("[TB] FAIL abort_first_load: got load=%b ammo=%0d expected load=1 ammo=16", load, ammo_out); else pass_cnt++;
        firing = 1'b1;
        tick();
        check_cnt++; if (error !== 1'b1) $display("[TB] FAIL abort_error: got %b expected 1", error); else pass_cnt++;
        check_cnt++; if (load !== 1'b0) $display("[TB] FAIL abort_no_load: got %b expected 0", load); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b expected 0", busy); else pass_cnt++;
        firing = 1'b0;
        capture(8);
        check_cnt++; if (n_loads != 0) $display("[TB] FAIL abort_later_loads: got %0d expected 0", n_loads); else pass_cnt++;
        check_cnt++; if (reserve !== 9'd84) $display("[TB] FAIL abort_reserve: got %0d expected 84", reserve); else pass_cnt++;
    endtask

    task automatic test_saturation();
        do_reset();
        store(510);
        weapon_ammo = 9'd0;
        weapon_max  = 9'd100;
        reload_req  = 1'b1;
        tick();
        reload_req = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        store_load = 1'b1;
        store_in   = 9'd20;
        tick();
        store_load = 1'b0;
        store_in   = '0;
        check_cnt++; if (reserve !== 9'd511) $display("[TB] FAIL sat_reserve: got %0d expected 511", reserve); else pass_cnt++;
        check_cnt++; if (load !== 1'b1 || ammo_out !== 9'd16) $display("[TB] FAIL sat_chunk: got load=%b ammo=%0d expected load=1 ammo=16", load, ammo_out); else pass_cnt++;
        capture(20);
        check_cnt++; if (n_loads != 6 || load_val[5] != 100) $display("[TB] FAIL sat_rest_loads: got n=%0d last=%0d expected n=6 last=100", n_loads, load_val[5]); else pass_cnt++;
        check_cnt++; if (n_done != 1) $display("[TB] FAIL sat_done: got %0d expected 1", n_done); else pass_cnt++;
        check_cnt++; if (reserve !== 9'd427) $display("[TB] FAIL sat_final_reserve: got %0d expected 427", reserve); else pass_cnt++;
    endtask

    task automatic test_full_weapon();
        do_reset();
        store(100);
        weapon_ammo = 9'd50;
        weapon_max  = 9'd50;
        reload_req  = 1'b1;
        tick();
        check_cnt++; if (busy !== 1'b0 || error !== 1'b0) $display("[TB] FAIL full_flags: got busy=%b error=%b expected 0 0", busy, error); else pass_cnt++;
        capture(8);
        reload_req = 1'b0;
        check_cnt++; if (n_loads != 0 || n_done != 0 || n_err != 0) $display("[TB] FAIL full_activity: got loads=%0d done=%0d err=%0d expected 0 0 0", n_loads, n_done, n_err); else pass_cnt++;
        check_cnt++; if (reserve !== 9'd100) $display("[TB] FAIL full_reserve: got %0d expected 100", reserve); else pass_cnt++;
    endtask

    task automatic test_reset_mid_transfer();
        do_reset();
        store(100);
        weapon_ammo = 9'd0;
        weapon_max  = 9'd40;
        reload_req  = 1'b1;
        tick();
        reload_req = 1'b0;
        for (int i = 1; i <= 5; i++) tick();
        rst = 1'b1;
        tick();
        check_cnt++; if (load !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL rstmid_flags: got load=%b busy=%b expected 0 0", load, busy); else pass_cnt++;
        check_cnt++; if (reserve !== 9'd0 || ammo_out !== 9'd0) $display("[TB] FAIL rstmid_regs: got reserve=%0d ammo=%0d expected 0 0", reserve, ammo_out); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        store(100);
        weapon_ammo = 9'd0;
        weapon_max  = 9'd20;
        reload_req  = 1'b1;
        tick();
        capture(17);
        reload_req = 1'b0;
        check_cnt++; if (n_loads != 4) $display("[TB] FAIL b2b_nloads: got %0d expected 4", n_loads); else pass_cnt++;
        check_cnt++; if (load_val[0] != 16 || load_val[1] != 20 || load_val[2] != 16 || load_val[3] != 20)
            $display("[TB] FAIL b2b_values: got %0d,%0d,%0d,%0d expected 16,20,16,20", load_val[0], load_val[1], load_val[2], load_val[3]); else pass_cnt++;
        check_cnt++; if (load_idx[2] != 14) $display("[TB] FAIL b2b_rearm_cycle: got %0d expected 14", load_idx[2]); else pass_cnt++;
        check_cnt++; if (n_done != 2) $display("[TB] FAIL b2b_done: got %0d expected 2", n_done); else pass_cnt++;
        check_cnt++; if (reserve !== 9'd60) $display("[TB] FAIL b2b_reserve: got %0d expected 60", reserve); else pass_cnt++;
    endtask

`ifdef AUTO_RELOAD_EN
    task automatic test_auto_reload();
        do_reset();
        weapon_ammo = 9'd31;
        weapon_max  = 9'd100;
        store(10);
        capture(12);
        check_cnt++; if (n_loads != 1 || load_val[0] != 41) $display("[TB] FAIL auto_load: got n=%0d val=%0d expected n=1 val=41", n_loads, load_val[0]); else pass_cnt++;
        check_cnt++; if (n_done != 1 || n_err != 0) $display("[TB] FAIL auto_done: got done=%0d err=%0d expected 1 0", n_done, n_err); else pass_cnt++;
        check_cnt++; if (reserve !== 9'd0) $display("[TB] FAIL auto_reserve: got %0d expected 0", reserve); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_transfer();
        test_empty_reserve();
        test_firing_abort();
        test_saturation();
        test_full_weapon();
        test_reset_mid_transfer();
        test_back_to_back();
`ifdef AUTO_RELOAD_EN
        test_auto_reload();
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
